// File: rtl/gpr_block_sequencer.sv
// Walks the 80186 general-purpose registers through PUSHA/POPA block transfers,
// driving one register-file read port, the write port and a 16-bit stack memory handshake.
module gpr_block_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_pop,
  input  logic [15:0] sp_in,
  output logic        busy,
  output logic        done,
  output logic [2:0]  rf_rd_sel,
  input  logic [15:0] rf_rd_val,
  output logic        rf_is_8_bit,
  output logic [2:0]  rf_wr_sel,
  output logic [15:0] rf_wr_val,
  output logic        rf_wr_en,
  output logic        mem_access,
  output logic        mem_wr_en,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data_out,
  input  logic [15:0] mem_data_in,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    PUSH_MEM,
    POP_MEM,
    POP_WR,
    SP_WB,
    DONE
  } state_t;

  localparam logic [2:0] SP_SEL = 3'd4;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] sp_base_q, sp_base_d;
  logic [15:0] data_reg_q, data_reg_d;
  logic        is_pop_q, is_pop_d;

  // Register encoding is AX..DI = 0..7, so push order is idx itself and pop order is 7-idx.
  logic [2:0]  push_reg;
  logic [2:0]  pop_reg;
  logic [15:0] slot_offset;

  assign push_reg    = idx_q;
  assign pop_reg     = ~idx_q;
  assign slot_offset = {12'd0, idx_q, 1'b0};
  assign rf_is_8_bit = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      sp_base_q  <= 16'd0;
      data_reg_q <= 16'd0;
      is_pop_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sp_base_q  <= sp_base_d;
      data_reg_q <= data_reg_d;
      is_pop_q   <= is_pop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sp_base_d    = sp_base_q;
    data_reg_d   = data_reg_q;
    is_pop_d     = is_pop_q;
    busy         = 1'b0;
    done         = 1'b0;
    rf_rd_sel    = 3'd0;
    rf_wr_sel    = 3'd0;
    rf_wr_val    = 16'd0;
    rf_wr_en     = 1'b0;
    mem_access   = 1'b0;
    mem_wr_en    = 1'b0;
    mem_address  = 16'd0;
    mem_data_out = 16'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sp_base_d = sp_in;
          idx_d     = 3'd0;
          is_pop_d  = is_pop;
          state_d   = is_pop ? POP_MEM : FETCH;
        end
      end
      FETCH: begin
        busy      = 1'b1;
        rf_rd_sel = push_reg;
        state_d   = LATCH;
      end
      LATCH: begin
        busy       = 1'b1;
        rf_rd_sel  = push_reg;
        // PUSHA stores the SP value from before the instruction, not the live register.
        data_reg_d = (idx_q == SP_SEL) ? sp_base_q : rf_rd_val;
        state_d    = PUSH_MEM;
      end
      PUSH_MEM: begin
        busy         = 1'b1;
        mem_access   = 1'b1;
        mem_wr_en    = 1'b1;
        mem_address  = sp_base_q - slot_offset - 16'd2;
        mem_data_out = data_reg_q;
        if (mem_ack) begin
          idx_d   = idx_q + 3'd1;
          state_d = (idx_q == 3'd7) ? SP_WB : FETCH;
        end
      end
      POP_MEM: begin
        busy        = 1'b1;
        mem_access  = 1'b1;
        mem_address = sp_base_q + slot_offset;
        if (mem_ack) begin
          data_reg_d = mem_data_in;
          state_d    = POP_WR;
        end
      end
      POP_WR: begin
        busy      = 1'b1;
        rf_wr_sel = pop_reg;
        rf_wr_val = data_reg_q;
        rf_wr_en  = (pop_reg != SP_SEL);
        idx_d     = idx_q + 3'd1;
        state_d   = (idx_q == 3'd7) ? SP_WB : POP_MEM;
      end
      SP_WB: begin
        busy      = 1'b1;
        rf_wr_en  = 1'b1;
        rf_wr_sel = SP_SEL;
        rf_wr_val = is_pop_q ? (sp_base_q + 16'd16) : (sp_base_q - 16'd16);
        state_d   = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpr_block_sequencer.sv
// Self-checking bench: register file and stack memory models plus a transfer-level
// reference that predicts every memory access and register write of PUSHA/POPA.
module tb_gpr_block_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_pop;
  logic [15:0] sp_in;
  logic        busy;
  logic        done;
  logic [2:0]  rf_rd_sel;
  logic [15:0] rf_rd_val;
  logic        rf_is_8_bit;
  logic [2:0]  rf_wr_sel;
  logic [15:0] rf_wr_val;
  logic        rf_wr_en;
  logic        mem_access;
  logic        mem_wr_en;
  logic [15:0] mem_address;
  logic [15:0] mem_data_out;
  logic [15:0] mem_data_in;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  logic [15:0] regs [8];
  logic [15:0] mem  [65536];
  int          memWait = 0;
  int          waitCnt = 0;
  logic [32:0] memLog [$];
  logic [18:0] rfLog  [$];
  logic [15:0] holdAddr;
  logic [15:0] holdData;
  logic        holdWr;

  gpr_block_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_pop       (is_pop),
    .sp_in        (sp_in),
    .busy         (busy),
    .done         (done),
    .rf_rd_sel    (rf_rd_sel),
    .rf_rd_val    (rf_rd_val),
    .rf_is_8_bit  (rf_is_8_bit),
    .rf_wr_sel    (rf_wr_sel),
    .rf_wr_val    (rf_wr_val),
    .rf_wr_en     (rf_wr_en),
    .mem_access   (mem_access),
    .mem_wr_en    (mem_wr_en),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register file: synchronous read, write applied when the strobe is seen.
  always @(posedge clk) rf_rd_val <= regs[rf_rd_sel];

  // Stack memory responder: acks after memWait wait cycles, checks the request holds steady.
  always @(negedge clk) begin
    if (mem_access) begin
      if (waitCnt == 0) begin
        holdAddr = mem_address;
        holdData = mem_data_out;
        holdWr   = mem_wr_en;
      end else begin
        checkOutput("hold_addr", {17'd0, mem_address}, {17'd0, holdAddr});
        checkOutput("hold_data", {17'd0, mem_data_out}, {17'd0, holdData});
        checkOutput("hold_wr", {32'd0, mem_wr_en}, {32'd0, holdWr});
      end
      if (waitCnt >= memWait) begin
        mem_ack = 1'b1;
        if (mem_wr_en) begin
          mem[mem_address] = mem_data_out;
          memLog.push_back({1'b1, mem_address, mem_data_out});
        end else begin
          mem_data_in = mem[mem_address];
          memLog.push_back({1'b0, mem_address, mem[mem_address]});
        end
        waitCnt = 0;
      end else begin
        mem_ack = 1'b0;
        waitCnt++;
      end
    end else begin
      mem_ack = 1'b0;
      waitCnt = 0;
    end
    if (rf_wr_en) begin
      rfLog.push_back({rf_wr_sel, rf_wr_val});
      regs[rf_wr_sel] = rf_wr_val;
    end
  end

  task automatic applyStimulus(input logic pop, input logic [15:0] sp, input int waitN,
                               input bit pulseAgain, input int abortReq);
    logic [32:0] expMem [$];
    logic [18:0] expRf  [$];
    logic [15:0] addr;
    int cyc, reqs, expLat, r;
    logic prevAcc;
    memWait = waitN;
    memLog.delete();
    rfLog.delete();
    for (int i = 0; i < 8; i++) begin
      if (!pop) begin
        addr = sp - 16'(2 * (i + 1));
        expMem.push_back({1'b1, addr, (i == 4) ? sp : regs[i]});
      end else begin
        addr = sp + 16'(2 * i);
        r = 7 - i;
        expMem.push_back({1'b0, addr, mem[addr]});
        if (r != 4) expRf.push_back({3'(r), mem[addr]});
      end
    end
    expRf.push_back({3'd4, pop ? sp + 16'd16 : sp - 16'd16});
    expLat = (pop ? 18 : 26) + 8 * waitN;

    @(negedge clk);
    start = 1'b1; is_pop = pop; sp_in = sp;
    @(posedge clk);
    #1 start = 1'b0; is_pop = 1'($urandom); sp_in = 16'($urandom);
    cyc = 0; reqs = 0; prevAcc = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) checkOutput("busy_after_start", {32'd0, busy}, 33'd1);
      start = (pulseAgain && cyc == 5);
      if (mem_access && !prevAcc) reqs++;
      prevAcc = mem_access;
      if (abortReq != 0 && reqs == abortReq) begin
        #1 reset = 1'b1;
        #1;
        checkOutput("abort_busy", {32'd0, busy}, 33'd0);
        checkOutput("abort_mem_access", {32'd0, mem_access}, 33'd0);
        checkOutput("abort_rf_wr_en", {32'd0, rf_wr_en}, 33'd0);
        checkOutput("abort_done", {32'd0, done}, 33'd0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_no_sp_wb", 33'(rfLog.size()), 33'd0);
        return;
      end
    end while (!done && cyc < 400);
    start = 1'b0;
    checkOutput("done_latency", 33'(cyc), 33'(expLat));
    checkOutput("busy_in_done", {32'd0, busy}, 33'd1);
    @(negedge clk);
    checkOutput("done_one_pulse", {32'd0, done}, 33'd0);
    checkOutput("busy_after_done", {32'd0, busy}, 33'd0);
    checkOutput("mem_count", 33'(memLog.size()), 33'(expMem.size()));
    checkOutput("rf_count", 33'(rfLog.size()), 33'(expRf.size()));
    for (int i = 0; i < expMem.size() && i < memLog.size(); i++)
      checkOutput("mem_xfer", memLog[i], expMem[i]);
    for (int i = 0; i < expRf.size() && i < rfLog.size(); i++)
      checkOutput("rf_write", {14'd0, rfLog[i]}, {14'd0, expRf[i]});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_pop = 1'b0; sp_in = 16'd0;
    mem_ack = 1'b0; mem_data_in = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
    for (int i = 0; i < 8; i++) regs[i] = 16'(16'h1111 * (i + 1));
    #12;
    checkOutput("reset_busy", {32'd0, busy}, 33'd0);
    checkOutput("reset_done", {32'd0, done}, 33'd0);
    checkOutput("reset_mem_access", {32'd0, mem_access}, 33'd0);
    checkOutput("reset_rf_wr_en", {32'd0, rf_wr_en}, 33'd0);
    checkOutput("reset_mem_address", {17'd0, mem_address}, 33'd0);
    checkOutput("rf_is_8_bit", {32'd0, rf_is_8_bit}, 33'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] PUSHA zero-wait from SP=0100");
    applyStimulus(1'b0, 16'h0100, 0, 1'b0, 0);
    checkOutput("sp_after_push", {17'd0, regs[4]}, 33'h00F0);

    $display("[TB] POPA zero-wait from SP=00F0 with corrupted SP slot");
    mem[16'h00F6] = 16'hDEAD;
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
    applyStimulus(1'b1, 16'h00F0, 0, 1'b0, 0);
    checkOutput("pop_ax", {17'd0, regs[0]}, 33'h1111);
    checkOutput("pop_di", {17'd0, regs[7]}, 33'h8888);
    checkOutput("sp_after_pop", {17'd0, regs[4]}, 33'h0100);

    $display("[TB] PUSHA wrapping below zero");
    applyStimulus(1'b0, 16'h0004, 0, 1'b0, 0);
    checkOutput("sp_after_wrap", {17'd0, regs[4]}, 33'hFFF4);

    $display("[TB] PUSHA with three wait cycles per access");
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
    applyStimulus(1'b0, 16'($urandom), 3, 1'b0, 0);

    $display("[TB] PUSHA with a second start pulse mid-operation");
    applyStimulus(1'b0, 16'($urandom), 0, 1'b1, 0);

    $display("[TB] reset during third push access, then a clean PUSHA");
    applyStimulus(1'b0, 16'h2000, 3, 1'b0, 3);
    applyStimulus(1'b0, 16'h2000, 0, 1'b0, 0);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      applyStimulus(1'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
